fifo_feeder: RTL and testbench

- Upstream producer for the 4-entry, 4-bit fifo.
- On a start pulse it walks a block of 4-bit words in a synchronous program memory and packs each word into the fifo's 7-bit command vector as a write.
- Throttles itself on the fifo's full_flag, driving the halt encoding while the fifo is full.
- Raises a done pulse when the block has been delivered. Used by each core to preload its instruction queue.

---
 rtl/fifo_feeder_if.sv | 27 ++
 rtl/fifo_feeder.sv | 137 +++++++++++++
 tb/tb_fifo_feeder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_feeder_if.sv
// Memory-read and fifo-command bus between fifo_feeder (master) and its memory/fifo (slave).
// Latency: none (wires only); backpressure: full_flag from the fifo side.
interface fifo_feeder_if #(
    parameter int ADDR_W = 4
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_data;
    logic              full_flag;
    logic [6:0]        vector_out;

    modport master (
        output mem_rd_en,
        output mem_addr,
        output vector_out,
        input  mem_data,
        input  full_flag
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        input  vector_out,
        output mem_data,
        output full_flag
    );
endinterface

// File: rtl/fifo_feeder.sv
// fifo_feeder: packs program-memory words into fifo write vectors; first write 4 cycles after start, then 1 per 3 cycles.
// Backpressure: a high full_flag in PUSH/STALL holds the word and drives halt; FIFO_FEEDER_STALL_CNT_EN adds o_stall_count.
module fifo_feeder #(
    parameter int ADDR_W = 4,
    parameter int LEN_W  = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    fifo_feeder_if.master     bus,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [LEN_W-1:0]  i_length,
    output logic              o_busy,
    output logic              o_done
`ifdef FIFO_FEEDER_STALL_CNT_EN
    ,
    output logic [7:0]        o_stall_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CAPT,
        S_PUSH,
        S_STALL,
        S_DONE
    } state_t;

    localparam logic [6:0] VEC_HALT = 7'b000_0001;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [LEN_W-1:0]  r_remaining;
    logic [3:0]        r_hold;
    logic              r_mem_rd_en;
    logic [6:0]        r_vector;
    logic              r_busy;
    logic              r_done;

    logic [ADDR_W-1:0] w_ptr_nxt;
    logic              w_last;

    assign w_ptr_nxt = r_ptr + ADDR_W'(1);
    assign w_last    = (r_remaining == LEN_W'(1));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_mem_addr  <= '0;
            r_remaining <= '0;
            r_hold      <= '0;
            r_mem_rd_en <= 1'b0;
            r_vector    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_vector    <= '0;
            r_mem_rd_en <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_ptr       <= i_base_addr;
                        r_remaining <= i_length;
                        r_busy      <= 1'b1;
                        if (i_length == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_mem_addr  <= i_base_addr;
                            r_mem_rd_en <= 1'b1;
                            r_state     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    r_state <= S_CAPT;
                end
                S_CAPT: begin
                    r_hold  <= bus.mem_data;
                    r_state <= S_PUSH;
                end
                // The fifo's full_flag is only looked at here; the read pipeline ignores it.
                S_PUSH, S_STALL: begin
                    if (bus.full_flag) begin
                        r_vector <= VEC_HALT;
                        r_state  <= S_STALL;
                    end else begin
                        r_vector    <= {1'b1, 1'b0, r_hold, 1'b0};
                        r_ptr       <= w_ptr_nxt;
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_mem_addr  <= w_ptr_nxt;
                            r_mem_rd_en <= 1'b1;
                            r_state     <= S_REQ;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rd_en  = r_mem_rd_en;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.vector_out = r_vector;
    assign o_busy         = r_busy;
    assign o_done         = r_done;

`ifdef FIFO_FEEDER_STALL_CNT_EN
    logic [7:0] r_stall_count;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_stall_count <= '0;
        end else if (r_state == S_IDLE && i_start) begin
            r_stall_count <= '0;
        end else if (r_state == S_STALL && r_stall_count != 8'hFF) begin
            r_stall_count <= r_stall_count + 8'd1;
        end
    end

    assign o_stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fifo_feeder.sv
// Scoreboard bench for fifo_feeder: a cycle-level reference of writes, halts, reads and done, plus a fifo model.
`timescale 1ns/1ps
module tb_fifo_feeder;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] base_addr;
    logic [4:0] length;
    logic       busy;
    logic       done;
`ifdef FIFO_FEEDER_STALL_CNT_EN
    logic [7:0] stall_count;
`endif

    always #5 clk = ~clk;

    fifo_feeder_if #(.ADDR_W(4)) bus ();

    fifo_feeder #(.ADDR_W(4), .LEN_W(5)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .bus         (bus.master),
        .i_start     (start),
        .i_base_addr (base_addr),
        .i_length    (length),
        .o_busy      (busy),
        .o_done      (done)
`ifdef FIFO_FEEDER_STALL_CNT_EN
        ,
        .o_stall_count (stall_count)
`endif
    );

    logic [3:0] mem [16];
    always @(posedge clk) if (bus.mem_rd_en) bus.mem_data <= mem[bus.mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    bit sb_on  = 1'b0;
    bit fpat [600];

    typedef struct { int c; logic [6:0] v; logic d; } ev_t;
    typedef struct { int c; logic [3:0] a; } rd_t;
    ev_t evq[$];
    rd_t rdq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void push_ev(input int c, input logic [6:0] v, input logic d);
        ev_t e;
        e.c = c; e.v = v; e.d = d;
        evq.push_back(e);
    endfunction

    function automatic void push_rd(input int c, input logic [3:0] a);
        rd_t r;
        r.c = c; r.a = a;
        rdq.push_back(r);
    endfunction

    // Monitor: every non-idle output cycle must match the next expected event.
    always @(negedge clk) begin : mon
        ev_t e;
        rd_t r;
        if (sb_on && reset) begin
            if (bus.vector_out != 7'd0 || done) begin
                if (evq.size() == 0) begin
                    chk("unexpected_output", {24'd0, done, bus.vector_out}, 32'd0);
                end else begin
                    e = evq.pop_front();
                    chk("out_cycle", cyc, e.c);
                    chk("out_value", {24'd0, done, bus.vector_out}, {24'd0, e.d, e.v});
                end
            end
            if (bus.mem_rd_en) begin
                if (rdq.size() == 0) begin
                    chk("unexpected_read", 32'd1, 32'd0);
                end else begin
                    r = rdq.pop_front();
                    chk("read_cycle", cyc, r.c);
                    chk("read_addr", bus.mem_addr, r.a);
                end
            end
        end
    end

    // One transfer: build the expected timeline from the full_flag pattern, then drive it.
    task automatic run_xfer(input logic [3:0] b, input logic [4:0] l, input int pct,
                            input bit dup_start, input int abort_k, output int stalls);
        int s, p, d, last;
        stalls = 0;
        if (pct >= 0)
            for (int k = 0; k < 600; k++) fpat[k] = (k < 300) && ($urandom_range(99) < pct);
        @(posedge clk); #1;
        s = cyc;
        if (l == 0) begin
            push_ev(s + 2, 7'd0, 1'b1);
            last = s + 2;
        end else begin
            p = s + 3;
            d = p;
            for (int i = 0; i < int'(l); i++) begin
                logic [3:0] a;
                a = b + 4'(i);
                push_rd(p - 2, a);
                d = p;
                while (fpat[d - s]) d++;
                for (int h = p + 1; h <= d; h++) push_ev(h, 7'b000_0001, 1'b0);
                push_ev(d + 1, {2'b10, mem[a], 1'b0}, 1'b0);
                stalls += d - p;
                p = d + 3;
            end
            push_ev(d + 2, 7'd0, 1'b1);
            last = d + 2;
        end
        start = 1'b1; base_addr = b; length = l; bus.full_flag = fpat[0];
        for (int k = 1; k <= last - s + 1; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                start = 1'b0;
                chk("busy_after_start", busy, 1);
            end
            if (dup_start && k == 5) begin start = 1'b1; base_addr = 4'h5; length = 5'd7; end
            if (dup_start && k == 6) start = 1'b0;
            bus.full_flag = fpat[k];
            if (k == abort_k) begin
                #1 reset = 1'b0;
                #1;
                chk("arst_vector", bus.vector_out, 0);
                chk("arst_rd_en", bus.mem_rd_en, 0);
                chk("arst_addr", bus.mem_addr, 0);
                chk("arst_busy", busy, 0);
                chk("arst_done", done, 0);
                #1 reset = 1'b1;
                evq.delete();
                rdq.delete();
                bus.full_flag = 1'b0;
                return;
            end
        end
        chk("events_drained", evq.size(), 0);
        chk("reads_drained", rdq.size(), 0);
        chk("busy_idle", busy, 0);
`ifdef FIFO_FEEDER_STALL_CNT_EN
        chk("stall_count", stall_count, (stalls > 255) ? 255 : stalls);
`endif
    endtask

    // Feeder connected to a 4-deep fifo model with a consumer that reads twice once halted.
    task automatic integ();
        logic [3:0] fq[$];
        logic [3:0] expq[$];
        int nwr = 0, halts = 0, rd_left = 0;
        bit wr, fin = 1'b0, trig = 1'b0;
        logic [3:0] dat;
        sb_on = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mem[i] = 4'($urandom);
            expq.push_back(mem[i]);
        end
        @(posedge clk); #1;
        bus.full_flag = 1'b0; start = 1'b1; base_addr = 4'h0; length = 5'd6;
        for (int k = 0; k < 300 && !fin; k++) begin
            @(negedge clk);
            wr  = bus.vector_out[6];
            dat = bus.vector_out[4:1];
            if (bus.vector_out == 7'b000_0001) begin
                halts++;
                if (halts == 1) chk("integ_writes_before_full", nwr, 4);
            end
            if (done) fin = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (wr) begin
                if (fq.size() >= 4) chk("integ_overflow", fq.size(), 3);
                fq.push_back(dat);
                nwr++;
            end
            if (halts == 3 && !trig) begin trig = 1'b1; rd_left = 2; end
            if (rd_left > 0) begin
                rd_left--;
                chk("integ_read", fq.pop_front(), expq.pop_front());
            end
            bus.full_flag = (fq.size() == 4);
        end
        chk("integ_done", fin, 1);
        chk("integ_halted", trig, 1);
        while (fq.size() > 0 && expq.size() > 0) chk("integ_drain", fq.pop_front(), expq.pop_front());
        chk("integ_total_writes", nwr, 6);
        chk("integ_leftover", fq.size() + expq.size(), 0);
        bus.full_flag = 1'b0;
        sb_on = 1'b1;
    endtask

    initial begin
        int st;
        reset = 1'b0; start = 1'b0; base_addr = '0; length = '0; bus.full_flag = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vector", bus.vector_out, 0);
        chk("rst_rd_en", bus.mem_rd_en, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b1;
        sb_on = 1'b1;

        mem[0] = 4'hF; mem[1] = 4'hE; mem[2] = 4'hD; mem[3] = 4'h9;
        run_xfer(4'h0, 5'd4, 0, 1'b0, 0, st);

        for (int k = 0; k < 600; k++) fpat[k] = 1'b0;
        for (int k = 9; k <= 13; k++) fpat[k] = 1'b1;
        run_xfer(4'h0, 5'd4, -1, 1'b0, 0, st);
`ifdef FIFO_FEEDER_STALL_CNT_EN
        chk("bp_stall_count", stall_count, 5);
`endif

        run_xfer(4'h3, 5'd0, 0, 1'b0, 0, st);

        mem[14] = 4'h1; mem[15] = 4'h2; mem[0] = 4'h3;
        run_xfer(4'hE, 5'd3, 0, 1'b1, 0, st);

        for (int k = 0; k < 600; k++) fpat[k] = (k >= 9 && k <= 200);
        run_xfer(4'h0, 5'd4, -1, 1'b0, 12, st);
        run_xfer(4'h0, 5'd4, 0, 1'b0, 0, st);

        repeat (20) begin
            logic [4:0] l;
            int pct;
            for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);
            l = 5'($urandom_range(0, 18));
            case ($urandom_range(2))
                0: pct = 0;
                1: pct = 20;
                default: pct = 50;
            endcase
            run_xfer(4'($urandom), l, pct, (l >= 2) && ($urandom_range(1) == 1), 0, st);
        end

        integ();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
